sfp_row_seqdiv: RTL

- Parametrised softmax-normalisation row for the attention datapath; sits after the MAC array output, one instance per core row.
- Accumulate phase: sums |psum| across COL lanes and queues each row sum in an internal FIFO and an external FIFO. The external FIFO feeds the partner core.
- Divide phase: pops the local sum, adds the partner's sum, and divides every lane's |psum| by the shifted total.
- Division uses a shared-control, multi-cycle restoring divider per lane instead of a combinational divide.

---
 rtl/sfp_row_seqdiv.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/sfp_row_seqdiv.sv
// sfp_row_seqdiv: softmax row normaliser, |psum| row sums into two FIFOs, then per-lane restoring divide.
// Ports: clk/reset (async, active high), clk_en gates all state; acc sums |sfp_in| lanes into both
// sum FIFOs; div pops the internal FIFO and divides every lane by (local>>SUM_SHIFT)+(sum_in>>SUM_SHIFT);
// fifo_ext_rd pops the external FIFO whose head is sum_out; sfp_out/out_valid carry the quotients;
// busy, int_empty, ext_full, ovf report status.
// Option: define SFP_SIGN_RESTORE_EN to negate quotients of lanes whose input was negative.
module sfp_row_seqdiv #(
  parameter int COL = 8,
  parameter int BW_PSUM = 20,
  parameter int SUM_SHIFT = 7,
  parameter int FIFO_DEPTH = 16,
  localparam int SUM_W = BW_PSUM + $clog2(COL)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_en,
  input  logic                     acc,
  input  logic                     div,
  input  logic [COL*BW_PSUM-1:0]   sfp_in,
  input  logic [SUM_W-1:0]         sum_in,
  input  logic                     fifo_ext_rd,
  output logic [SUM_W-1:0]         sum_out,
  output logic [COL*BW_PSUM-1:0]   sfp_out,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     int_empty,
  output logic                     ext_full,
  output logic                     ovf
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(BW_PSUM + 1);
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  state_t state_q, state_d;
  logic [SUM_W-1:0] sum_q, sum_d, ext_last_q;
  logic acc_q, ovf_q, out_valid_q;
  logic [SUM_W-1:0] int_mem [FIFO_DEPTH];
  logic [SUM_W-1:0] ext_mem [FIFO_DEPTH];
  logic [AW:0] int_wp_q, int_rp_q, ext_wp_q, ext_rp_q;
  logic [COL*BW_PSUM-1:0] sfp_q, quo;
  logic [BW_PSUM-1:0] den_q, den_d;
  logic [BW_PSUM-1:0] rem_q [COL];
  logic [BW_PSUM-1:0] aq_q [COL];
  logic [BW_PSUM-1:0] rem_d [COL];
  logic [BW_PSUM-1:0] aq_d [COL];
  logic [BW_PSUM-1:0] lane_abs [COL];
  logic [CW-1:0] cnt_q;
  logic int_full, ext_empty, wr, ext_pop, accept, last;
`ifdef SFP_SIGN_RESTORE_EN
  logic [COL-1:0] neg_q;
`endif
  // aq_q starts as the dividend magnitude and shifts quotient bits in from the right
  for (genvar i = 0; i < COL; i++) begin : g_lane
    logic [BW_PSUM-1:0] x;
    logic [BW_PSUM:0] trial;
    logic ge;
    assign x = sfp_in[i*BW_PSUM +: BW_PSUM];
    assign lane_abs[i] = x[BW_PSUM-1] ? -x : x;
    assign trial = {rem_q[i], aq_q[i][BW_PSUM-1]};
    assign ge = trial >= {1'b0, den_q};
    assign rem_d[i] = ge ? trial[BW_PSUM-1:0] - den_q : trial[BW_PSUM-1:0];
    assign aq_d[i] = {aq_q[i][BW_PSUM-2:0], ge};
`ifdef SFP_SIGN_RESTORE_EN
    assign quo[i*BW_PSUM +: BW_PSUM] = neg_q[i] ? -aq_q[i] : aq_q[i];
`else
    assign quo[i*BW_PSUM +: BW_PSUM] = aq_q[i];
`endif
  end
  always_comb begin
    sum_d = '0;
    for (int k = 0; k < COL; k++) sum_d = sum_d + SUM_W'(lane_abs[k]);
  end
  assign int_empty = int_wp_q == int_rp_q;
  assign ext_empty = ext_wp_q == ext_rp_q;
  assign int_full  = (int_wp_q[AW-1:0] == int_rp_q[AW-1:0]) && (int_wp_q[AW] != int_rp_q[AW]);
  assign ext_full  = (ext_wp_q[AW-1:0] == ext_rp_q[AW-1:0]) && (ext_wp_q[AW] != ext_rp_q[AW]);
  // a row sum goes to both FIFOs or to neither, keeping them in step with the partner core
  assign wr        = acc_q && !int_full && !ext_full;
  assign ext_pop   = fifo_ext_rd && !ext_empty;
  assign den_d     = BW_PSUM'(int_mem[int_rp_q[AW-1:0]] >> SUM_SHIFT) + BW_PSUM'(sum_in >> SUM_SHIFT);
  assign sum_out   = ext_empty ? ext_last_q : ext_mem[ext_rp_q[AW-1:0]];
  assign sfp_out   = sfp_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;
  assign busy      = state_q != IDLE;
  always_comb begin
    accept  = state_q == IDLE && div && !int_empty;
    last    = state_q == DIV && cnt_q == CW'(BW_PSUM - 1);
    state_d = accept ? DIV : last ? DONE : state_q == DONE ? IDLE : state_q;
  end
  always_ff @(posedge clk)
    if (clk_en && wr) begin
      int_mem[int_wp_q[AW-1:0]] <= sum_q;
      ext_mem[ext_wp_q[AW-1:0]] <= sum_q;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q     <= IDLE;
      sum_q       <= '0;
      acc_q       <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      ext_last_q  <= '0;
      int_wp_q    <= '0;
      int_rp_q    <= '0;
      ext_wp_q    <= '0;
      ext_rp_q    <= '0;
      sfp_q       <= '0;
      den_q       <= '0;
      cnt_q       <= '0;
`ifdef SFP_SIGN_RESTORE_EN
      neg_q       <= '0;
`endif
      for (int k = 0; k < COL; k++) begin
        rem_q[k] <= '0;
        aq_q[k]  <= '0;
      end
    end else if (clk_en) begin
      state_q     <= state_d;
      acc_q       <= acc;
      out_valid_q <= state_q == DONE;
      if (acc) sum_q <= sum_d;
      if (acc_q && !wr) ovf_q <= 1'b1;
      if (wr) begin
        int_wp_q <= int_wp_q + (AW+1)'(1);
        ext_wp_q <= ext_wp_q + (AW+1)'(1);
      end
      if (ext_pop) begin
        ext_rp_q   <= ext_rp_q + (AW+1)'(1);
        ext_last_q <= ext_mem[ext_rp_q[AW-1:0]];
      end
      if (state_q == DONE) sfp_q <= quo;
      if (accept) begin
        int_rp_q <= int_rp_q + (AW+1)'(1);
        den_q    <= den_d;
        cnt_q    <= '0;
        for (int k = 0; k < COL; k++) begin
          rem_q[k] <= '0;
          aq_q[k]  <= lane_abs[k];
`ifdef SFP_SIGN_RESTORE_EN
          neg_q[k] <= sfp_in[k*BW_PSUM + BW_PSUM - 1];
`endif
        end
      end else if (state_q == DIV) begin
        cnt_q <= cnt_q + CW'(1);
        for (int k = 0; k < COL; k++) begin
          rem_q[k] <= rem_d[k];
          aq_q[k]  <= aq_d[k];
        end
      end
    end
endmodule
